// File: rtl/nist_pkg.sv
// Shared definitions for the entropy front-end and the NIST test stage.
package nist_pkg;
  // Conditioning mode encodings (2'b11 is reserved and behaves as bypass)
  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_VN     = 2'b01;
  localparam logic [1:0] MODE_XOR    = 2'b10;

  // Defaults shared with the test stage so sequence lengths always match
  localparam int SEQ_LEN_DEF   = 1024;
  localparam int RUN_LIMIT_DEF = 32;
endpackage

// File: rtl/rnd_health_rct.sv
// Repetition-count health test: counts consecutive equal samples and raises
// a sticky alarm once the run reaches RUN_LIMIT. Cleared only by rst.
module rnd_health_rct #(
  parameter int RUN_LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic smp,
  input  logic smp_vld,
  output logic stuck
);
  localparam int RW = $clog2(RUN_LIMIT + 1);
  localparam logic [RW-1:0] LIM = RW'(RUN_LIMIT);

  logic [RW-1:0] run;
  logic          prev;

  // run counter (saturating) and sticky alarm; run==0 marks "no previous sample"
  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= '0;
      prev  <= 1'b0;
      stuck <= 1'b0;
    end else begin
      if (smp_vld) begin
        prev <= smp;
        if (run == '0 || smp != prev) run <= RW'(1);
        else if (run != LIM)          run <= run + 1'b1;
      end
      if (run == LIM) stuck <= 1'b1;
    end
  end
endmodule

// File: rtl/rnd_conditioner.sv
// Entropy front-end: 2-flop synchroniser, optional von Neumann / XOR-pair
// debiasing, sequence framing and a repetition-count stuck alarm.
module rnd_conditioner
  import nist_pkg::*;
#(
  parameter int SEQ_LEN   = SEQ_LEN_DEF,
  parameter int RUN_LIMIT = RUN_LIMIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       RND_raw,
  input  logic [1:0]                 mode,
  output logic                       RND_out,
  output logic                       RND_valid,
  output logic                       seq_start,
  output logic                       seq_done,
  output logic [$clog2(SEQ_LEN)-1:0] bit_cnt,
  output logic                       stuck
);
  localparam int CW = $clog2(SEQ_LEN);
  localparam logic PH_FIRST  = 1'b0;
  localparam logic PH_SECOND = 1'b1;

  logic          s1, s;
  logic [1:0]    vld_pipe;   // s is a real sample only once the sync chain refilled
  logic          s_vld;
  logic [1:0]    mode_q, mode_eff;
  logic          phase, phase_eff, phase_nxt;
  logic          a, a_nxt;
  logic          emit, emit_bit;
  logic          vld_q;
  logic [CW-1:0] cnt_nxt;    // index the next emitted bit will carry

  assign s_vld = vld_pipe[1];

  // two-flop synchroniser for the asynchronous raw pin
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s        <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1       <= RND_raw;
      s        <= s1;
      vld_pipe <= {vld_pipe[0], 1'b1};
    end
  end

  rnd_health_rct #(.RUN_LIMIT(RUN_LIMIT)) u_rct (
    .clk     (clk),
    .rst     (rst),
    .smp     (s),
    .smp_vld (s_vld),
    .stuck   (stuck)
  );

  // The sample processed in the seq_done cycle is the first of the next
  // sequence, so it must already see the newly loaded mode and a fresh pair.
  assign mode_eff  = seq_done ? mode : mode_q;
  assign phase_eff = seq_done ? PH_FIRST : phase;

  // pair FSM next-state and emit decision
  always_comb begin
    emit      = 1'b0;
    emit_bit  = s;
    phase_nxt = phase_eff;
    a_nxt     = a;
    if (s_vld && !stuck) begin
      case (mode_eff)
        MODE_VN, MODE_XOR: begin
          if (phase_eff == PH_FIRST) begin
            a_nxt     = s;
            phase_nxt = PH_SECOND;
          end else begin
            phase_nxt = PH_FIRST;
            if (mode_eff == MODE_VN) begin
              emit     = a ^ s;   // only unequal pairs emit; (0,1)->0, (1,0)->1
              emit_bit = a;
            end else begin
              emit     = 1'b1;
              emit_bit = a ^ s;
            end
          end
        end
        default: begin
          emit      = 1'b1;
          emit_bit  = s;
          phase_nxt = PH_FIRST;
        end
      endcase
    end
  end

  // mode latch and pair state
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= mode;
      phase  <= PH_FIRST;
      a      <= 1'b0;
    end else begin
      if (seq_done) mode_q <= mode;
      phase <= phase_nxt;
      a     <= a_nxt;
    end
  end

  // output register and framing counter
  always_ff @(posedge clk) begin
    if (rst) begin
      RND_out <= 1'b0;
      vld_q   <= 1'b0;
      bit_cnt <= '0;
      cnt_nxt <= '0;
    end else begin
      vld_q <= emit;
      if (emit) begin
        RND_out <= emit_bit;
        bit_cnt <= cnt_nxt;
        cnt_nxt <= cnt_nxt + 1'b1;
      end
    end
  end

  // stuck masks a strobe already sitting in the output register
  assign RND_valid = vld_q & ~stuck;
  assign seq_start = RND_valid & (bit_cnt == '0);
  assign seq_done  = RND_valid & (bit_cnt == CW'(SEQ_LEN - 1));
endmodule

// File: tb/tb_rnd_conditioner.sv
// Directed bench for rnd_conditioner with SEQ_LEN=8, RUN_LIMIT=32.
module tb_rnd_conditioner;
  import nist_pkg::*;

  logic       clk, rst, RND_raw;
  logic [1:0] mode;
  logic       RND_out, RND_valid, seq_start, seq_done, stuck;
  logic [2:0] bit_cnt;
  int n_vec = 0;
  int n_err = 0;

  rnd_conditioner #(.SEQ_LEN(8), .RUN_LIMIT(32)) dut (
    .clk(clk), .rst(rst), .RND_raw(RND_raw), .mode(mode),
    .RND_out(RND_out), .RND_valid(RND_valid), .seq_start(seq_start),
    .seq_done(seq_done), .bit_cnt(bit_cnt), .stuck(stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After this returns, the next rising edge is edge 1 of the new run.
  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1; mode = m;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(input logic r);
    RND_raw = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    do_reset(MODE_BYPASS);
    for (int i = 0; i < 6; i++) step(i[0]);
    rst = 1'b1;
    step(1'b1);
    n_vec++;
    if ({RND_out, RND_valid, seq_start, seq_done, stuck, bit_cnt} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs got %b want 00000000",
               {RND_out, RND_valid, seq_start, seq_done, stuck, bit_cnt});
    end
    rst = 1'b0;
  endtask

  // raw 1,0,1,0...: bit k appears after edge k+3
  task automatic test_bypass;
    logic [7:0] exp_o, got;
    int k;
    do_reset(MODE_BYPASS);
    for (int i = 0; i < 20; i++) begin
      step(~i[0]);
      exp_o = 8'h00;
      if (i + 1 >= 3) begin
        k = i - 2;
        exp_o = {1'b1, ~k[0], (k % 8) == 0, (k % 8) == 7, 1'b0, 3'(k % 8)};
      end
      got = {RND_valid, RND_out, seq_start, seq_done, stuck, bit_cnt};
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL bypass edge %0d got %b want %b", i + 1, got, exp_o);
      end
    end
  endtask

  task automatic test_vn;
    bit rv[16] = '{0,1, 1,1, 1,0, 0,0, 1,0, 1,1, 1,1, 1,1};
    int se[3]  = '{4, 8, 12};
    bit sb[3]  = '{0, 1, 1};
    int n = 0;
    logic ev;
    do_reset(MODE_VN);
    for (int i = 0; i < 16; i++) begin
      step(rv[i]);
      ev = (n < 3) && (se[n] == i + 1);
      n_vec++;
      if (RND_valid !== ev) begin
        n_err++;
        $display("FAIL vn_valid edge %0d got %b want %b", i + 1, RND_valid, ev);
      end
      if (ev) begin
        n_vec++;
        if ({RND_out, seq_start, seq_done, bit_cnt} !== {sb[n], n == 0, 1'b0, 3'(n)}) begin
          n_err++;
          $display("FAIL vn_bit %0d got %b want %b", n,
                   {RND_out, seq_start, seq_done, bit_cnt}, {sb[n], n == 0, 1'b0, 3'(n)});
        end
        n++;
      end
    end
  endtask

  task automatic test_xor;
    bit rv[11] = '{1,1, 1,0, 0,1, 0,0, 0,0, 0};
    int se[4]  = '{4, 6, 8, 10};
    bit sb[4]  = '{0, 1, 1, 0};
    int n = 0;
    logic ev;
    do_reset(MODE_XOR);
    for (int i = 0; i < 11; i++) begin
      step(rv[i]);
      ev = (n < 4) && (se[n] == i + 1);
      n_vec++;
      if (RND_valid !== ev) begin
        n_err++;
        $display("FAIL xor_valid edge %0d got %b want %b", i + 1, RND_valid, ev);
      end
      if (ev) begin
        n_vec++;
        if ({RND_out, bit_cnt} !== {sb[n], 3'(n)}) begin
          n_err++;
          $display("FAIL xor_bit %0d got %b want %b", n, {RND_out, bit_cnt}, {sb[n], 3'(n)});
        end
        n++;
      end
    end
  endtask

  // run hits 32 at edge 34, alarm visible after edge 35 and masks that strobe
  task automatic test_stuck;
    logic ev, es;
    do_reset(MODE_BYPASS);
    for (int i = 0; i < 42; i++) begin
      step(1'b1);
      ev = (i + 1 >= 3) && (i + 1 <= 34);
      es = (i + 1 >= 35);
      n_vec++;
      if ({RND_valid, stuck} !== {ev, es}) begin
        n_err++;
        $display("FAIL stuck edge %0d got valid/stuck %b want %b", i + 1, {RND_valid, stuck}, {ev, es});
      end
      if (es) begin
        n_vec++;
        if ({seq_start, seq_done} !== 2'b00) begin
          n_err++;
          $display("FAIL stuck_frame edge %0d got %b want 00", i + 1, {seq_start, seq_done});
        end
      end
    end
    do_reset(MODE_BYPASS);
    n_vec++;
    if (stuck !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_clear got %b want 0", stuck);
    end
  endtask

  // mode 00->01 while bit 3 is on the output; VN starts after seq_done
  task automatic test_mode_change;
    bit rv[16] = '{1,0,1,0,1,0,1,0, 1,1, 0,1, 1,0, 1,0};
    int se[10] = '{3,4,5,6,7,8,9,10, 14,16};
    bit sb[10] = '{1,0,1,0,1,0,1,0, 0,1};
    int sc[10] = '{0,1,2,3,4,5,6,7, 0,1};
    int n = 0;
    logic ev;
    logic [5:0] eo;
    do_reset(MODE_BYPASS);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) mode = MODE_VN;
      step(rv[i]);
      ev = (n < 10) && (se[n] == i + 1);
      n_vec++;
      if (RND_valid !== ev) begin
        n_err++;
        $display("FAIL modechg_valid edge %0d got %b want %b", i + 1, RND_valid, ev);
      end
      if (ev) begin
        eo = {sb[n], sc[n] == 0, sc[n] == 7, 3'(sc[n])};
        n_vec++;
        if ({RND_out, seq_start, seq_done, bit_cnt} !== eo) begin
          n_err++;
          $display("FAIL modechg_bit edge %0d got %b want %b", i + 1,
                   {RND_out, seq_start, seq_done, bit_cnt}, eo);
        end
        n++;
      end
    end
  endtask

  task automatic test_rst_mid;
    do_reset(MODE_BYPASS);
    for (int i = 0; i < 8; i++) step(~i[0]);
    n_vec++;
    if ({RND_valid, bit_cnt} !== {1'b1, 3'd5}) begin
      n_err++;
      $display("FAIL rstmid_pre got %b want 1101", {RND_valid, bit_cnt});
    end
    rst = 1'b1;
    step(1'b1);
    n_vec++;
    if ({RND_out, RND_valid, seq_start, seq_done, stuck, bit_cnt} !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_outputs got %b want 00000000",
               {RND_out, RND_valid, seq_start, seq_done, stuck, bit_cnt});
    end
    rst = 1'b0;
    step(1'b0);
    step(1'b1);
    n_vec++;
    if (RND_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_refill got %b want 0", RND_valid);
    end
    step(1'b0);
    n_vec++;
    if ({RND_valid, RND_out, seq_start, seq_done, bit_cnt} !== 7'b1010000) begin
      n_err++;
      $display("FAIL rstmid_first got %b want 1010000",
               {RND_valid, RND_out, seq_start, seq_done, bit_cnt});
    end
  endtask

  initial begin
    rst = 1'b1; RND_raw = 1'b0; mode = MODE_BYPASS;
    test_reset();
    test_bypass();
    test_vn();
    test_xor();
    test_stuck();
    test_mode_change();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
